cmp_sweep: RTL and testbench

CMP_SWEEP -- requirements
Module: cmp_sweep

---
 rtl/cmp_pkg.sv | 18 +
 rtl/cmp_unit.sv | 18 +
 rtl/cmp_sweep.sv | 108 ++++++++++
 tb/tb_cmp_sweep.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the candidate-sweep comparator: FSM states and compare-mode encodings.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic KEY_DIFF = 1'b0;
  localparam logic KEY_EQ   = 1'b1;

  // Equality mode matches only when every bit agrees; difference mode is its complement.
  function automatic logic cmp_match(input logic key, input logic all_equal);
    return (key == KEY_EQ) ? all_equal : ~all_equal;
  endfunction

endpackage

// File: rtl/cmp_unit.sv
// Combinational operand comparator: r is the match result for one candidate y against target x.
module cmp_unit
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             key,
  output logic             r
);

  logic all_equal;

  assign all_equal = (x == y);
  assign r         = cmp_match(key, all_equal);

endmodule

// File: rtl/cmp_sweep.sv
// Sweeps every candidate 0..DEPTH-1 against a latched target and records which ones match.
// Build option CMP_SWEEP_EARLY_STOP_EN ends an equality sweep right after its first hit.
module cmp_sweep
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             key,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y_out,
  output logic [DEPTH-1:0] hit_map,
  output logic [WIDTH:0]   hit_cnt,
  output logic [WIDTH-1:0] first_hit,
  output logic             found
);

  localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(DEPTH - 1);

  state_t           state;
  logic [WIDTH-1:0] x_q;
  logic             key_q;
  logic             r_c;
  logic             last_c;
  logic             stop_c;

  cmp_unit #(.WIDTH(WIDTH)) u_cmp (
    .x   (x_q),
    .y   (y_out),
    .key (key_q),
    .r   (r_c)
  );

  assign last_c = (y_out == Y_LAST);

`ifdef CMP_SWEEP_EARLY_STOP_EN
  // Equality has at most one match, so nothing is lost by stopping on it.
  assign stop_c = last_c || ((key_q == KEY_EQ) && r_c);
`else
  assign stop_c = last_c;
`endif

  // Sweep controller with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_q       <= '0;
      key_q     <= KEY_DIFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      y_out     <= '0;
      hit_map   <= '0;
      hit_cnt   <= '0;
      first_hit <= '0;
      found     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_q       <= x;
            key_q     <= key;
            hit_map   <= '0;
            hit_cnt   <= '0;
            first_hit <= '0;
            found     <= 1'b0;
            y_out     <= '0;
            busy      <= 1'b1;
            state     <= SWEEP;
          end
        end
        SWEEP: begin
          if (r_c) begin
            hit_map[y_out] <= 1'b1;
            hit_cnt        <= hit_cnt + (WIDTH + 1)'(1);
            if (!found) begin
              first_hit <= y_out;
              found     <= 1'b1;
            end
          end
          // y_out is left on the last candidate rather than wrapping.
          if (stop_c) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            y_out <= y_out + WIDTH'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sweep.sv
// Directed self-checking bench for cmp_sweep (WIDTH=3, DEPTH=8).
module tb_cmp_sweep;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       key;
  logic [2:0] x;
  logic       busy;
  logic       done;
  logic [2:0] y_out;
  logic [7:0] hit_map;
  logic [3:0] hit_cnt;
  logic [2:0] first_hit;
  logic       found;

  int checks = 0;
  int errors = 0;

`ifdef CMP_SWEEP_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  cmp_sweep dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .x         (x),
    .busy      (busy),
    .done      (done),
    .y_out     (y_out),
    .hit_map   (hit_map),
    .hit_cnt   (hit_cnt),
    .first_hit (first_hit),
    .found     (found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep from IDLE; lat is the cycle (1 = first SWEEP cycle) in which done is seen, 0 on timeout.
  task automatic do_sweep(input logic k, input logic [2:0] xv, output int lat);
    key   = k;
    x     = xv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    key   = 1'b0;
    x     = 3'b000;
    tick();
    tick();
    checks++;
    if ({busy, done, y_out, hit_map, hit_cnt, first_hit, found} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {busy, done, y_out, hit_map, hit_cnt, first_hit, found});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_difference();
    int lat;
    key   = 1'b0;
    x     = 3'b101;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (i <= 8) begin
        checks++;
        if (y_out !== 3'(i - 1) || busy !== 1'b1) begin
          errors++;
          $display("FAIL diff_scan cycle %0d got y_out=%0d busy=%b required %0d 1", i, y_out, busy, i - 1);
        end
      end
      x   = ~x;
      key = ~key;
      tick();
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL diff_latency got %0d required 9", lat);
    end
    checks++;
    if (hit_map !== 8'hDF || hit_cnt !== 4'd7 || first_hit !== 3'd0 || found !== 1'b1) begin
      errors++;
      $display("FAIL diff_result got map=%h cnt=%0d first=%0d found=%b required df 7 0 1",
               hit_map, hit_cnt, first_hit, found);
    end
    checks++;
    if (busy !== 1'b1 || y_out !== 3'd7) begin
      errors++;
      $display("FAIL diff_done_state got busy=%b y_out=%0d required 1 7", busy, y_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL diff_done_pulse got done=%b busy=%b required 0 0", done, busy);
    end
    x   = 3'b000;
    key = 1'b1;
    tick();
    tick();
    checks++;
    if (hit_map !== 8'hDF || hit_cnt !== 4'd7 || first_hit !== 3'd0 || found !== 1'b1) begin
      errors++;
      $display("FAIL diff_hold got map=%h cnt=%0d first=%0d found=%b required df 7 0 1",
               hit_map, hit_cnt, first_hit, found);
    end
  endtask

  task automatic test_equality();
    int lat;
    do_sweep(1'b1, 3'b011, lat);
    checks++;
    if (lat !== (EARLY ? 5 : 9)) begin
      errors++;
      $display("FAIL eq_latency got %0d required %0d", lat, EARLY ? 5 : 9);
    end
    checks++;
    if (hit_map !== 8'h08 || hit_cnt !== 4'd1 || first_hit !== 3'd3 || found !== 1'b1) begin
      errors++;
      $display("FAIL eq_result got map=%h cnt=%0d first=%0d found=%b required 08 1 3 1",
               hit_map, hit_cnt, first_hit, found);
    end
    tick();
  endtask

  task automatic test_start_held();
    int lat;
    key   = 1'b0;
    x     = 3'b000;
    start = 1'b1;
    tick();
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      x   = ~x;
      key = ~key;
      tick();
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL held_latency got %0d required 9", lat);
    end
    checks++;
    if (hit_map !== 8'hFE || hit_cnt !== 4'd7 || first_hit !== 3'd1 || found !== 1'b1) begin
      errors++;
      $display("FAIL held_result got map=%h cnt=%0d first=%0d found=%b required fe 7 1 1",
               hit_map, hit_cnt, first_hit, found);
    end
    key = 1'b1;
    x   = 3'b010;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL held_idle got busy=%b done=%b required 0 0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || y_out !== 3'd0 || hit_map !== 8'h00 || found !== 1'b0) begin
      errors++;
      $display("FAIL held_restart got busy=%b y_out=%0d map=%h found=%b required 1 0 00 0",
               busy, y_out, hit_map, found);
    end
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      x   = ~x;
      key = ~key;
      tick();
    end
    checks++;
    if (lat !== (EARLY ? 4 : 9)) begin
      errors++;
      $display("FAIL held2_latency got %0d required %0d", lat, EARLY ? 4 : 9);
    end
    checks++;
    if (hit_map !== 8'h04 || hit_cnt !== 4'd1 || first_hit !== 3'd2 || found !== 1'b1) begin
      errors++;
      $display("FAIL held2_result got map=%h cnt=%0d first=%0d found=%b required 04 1 2 1",
               hit_map, hit_cnt, first_hit, found);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen_done;
    key   = 1'b0;
    x     = 3'b101;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && y_out !== 3'd4; i++) tick();
    checks++;
    if (y_out !== 3'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach got y_out=%0d busy=%b required 4 1", y_out, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, y_out, hit_map, hit_cnt, first_hit, found} !== 21'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h required 0",
               {busy, done, y_out, hit_map, hit_cnt, first_hit, found});
    end
    tick();
    rst_n     = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done++;
      tick();
    end
    checks++;
    if (seen_done !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done got done_cycles=%0d busy=%b required 0 0", seen_done, busy);
    end
    do_sweep(1'b0, 3'b101, lat);
    checks++;
    if (lat !== 9 || hit_map !== 8'hDF || hit_cnt !== 4'd7 || first_hit !== 3'd0 || found !== 1'b1) begin
      errors++;
      $display("FAIL mid_resweep got lat=%0d map=%h cnt=%0d first=%0d found=%b required 9 df 7 0 1",
               lat, hit_map, hit_cnt, first_hit, found);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_sweep(1'b0, 3'b111, lat);
    checks++;
    if (lat !== 9 || hit_map !== 8'h7F || hit_cnt !== 4'd7 || first_hit !== 3'd0 || found !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d map=%h cnt=%0d first=%0d found=%b required 9 7f 7 0 1",
               lat, hit_map, hit_cnt, first_hit, found);
    end
    tick();
    do_sweep(1'b1, 3'b000, lat);
    checks++;
    if (lat !== (EARLY ? 2 : 9)) begin
      errors++;
      $display("FAIL b2b_latency got %0d required %0d", lat, EARLY ? 2 : 9);
    end
    checks++;
    if (hit_map !== 8'h01 || hit_cnt !== 4'd1 || first_hit !== 3'd0 || found !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got map=%h cnt=%0d first=%0d found=%b required 01 1 0 1",
               hit_map, hit_cnt, first_hit, found);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_difference();
    test_equality();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
